fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_skid.sv | 38 +++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared width, reset PC and state encoding for the fetch stage.
package fetch_pkg;
    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer holding a fetched instruction and its pc+1
// while decode is stalled; clear wins over unload, unload wins over load.
module fetch_skid #(
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_unload,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc1,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc1,
    output logic             o_valid
);
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc1;
    logic             r_valid;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_instr <= '0;
            r_pc1   <= '0;
            r_valid <= 1'b0;
        end else if (i_clear || i_unload) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc1   <= i_pc1;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc1   = r_pc1;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory handshake and IF/ID register; the PC
// incrementer lives outside and its result comes back on i_pc_plus1.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int WIDTH = fetch_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(fetch_pkg::RESET_PC)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_br_target,
    output logic [WIDTH-1:0] o_pc_out,
    input  logic [WIDTH-1:0] i_pc_plus1,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic [WIDTH-1:0] i_imem_data,
    input  logic             i_imem_valid,
    output logic [WIDTH-1:0] o_if_id_instr,
    output logic [WIDTH-1:0] o_if_id_pc1,
    output logic             o_if_id_valid
);
    fetch_state_t     r_state;
    fetch_state_t     w_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] r_if_instr;
    logic [WIDTH-1:0] r_if_pc1;
    logic             r_if_valid;
    logic [WIDTH-1:0] w_if_instr;
    logic [WIDTH-1:0] w_if_pc1;
    logic             w_if_valid;
    logic             w_req;
    logic             w_skid_load;
    logic             w_skid_unload;
    logic             w_skid_clear;
    logic [WIDTH-1:0] w_skid_instr;
    logic [WIDTH-1:0] w_skid_pc1;
    logic             w_skid_valid;

    fetch_skid #(.WIDTH(WIDTH)) u_skid (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_skid_load),
        .i_unload(w_skid_unload),
        .i_clear (w_skid_clear),
        .i_instr (i_imem_data),
        .i_pc1   (i_pc_plus1),
        .o_instr (w_skid_instr),
        .o_pc1   (w_skid_pc1),
        .o_valid (w_skid_valid)
    );

    always_comb begin
        w_next        = r_state;
        w_pc          = r_pc;
        w_if_instr    = r_if_instr;
        w_if_pc1      = r_if_pc1;
        w_if_valid    = r_if_valid & i_stall;
        w_req         = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_clear  = 1'b0;
        unique case (r_state)
            BOOT: w_next = FETCH;
            FETCH: begin
                w_req = 1'b1;
                if (i_imem_valid && !i_stall) begin
                    w_if_instr = i_imem_data;
                    w_if_pc1   = i_pc_plus1;
                    w_if_valid = 1'b1;
                    w_pc       = i_pc_plus1;
                end else if (i_imem_valid) begin
                    w_skid_load = 1'b1;
                    w_next      = HOLD;
                end
            end
            HOLD: if (!i_stall) begin
                w_if_instr    = w_skid_instr;
                w_if_pc1      = w_skid_pc1;
                w_if_valid    = w_skid_valid;
                w_pc          = w_skid_pc1;
                w_skid_unload = 1'b1;
                w_next        = FETCH;
            end
            DISCARD: w_next = i_imem_valid ? FETCH : DISCARD;
            default: w_next = BOOT;
        endcase
        // An outstanding response must still be swallowed after a redirect.
        if (i_flush) begin
            w_pc         = i_br_target;
            w_if_valid   = 1'b0;
            w_skid_load  = 1'b0;
            w_skid_clear = 1'b1;
            w_next       = ((r_state == FETCH || r_state == DISCARD) && !i_imem_valid) ? DISCARD : FETCH;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_if_instr <= '0;
            r_if_pc1   <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pc       <= w_pc;
            r_if_instr <= w_if_instr;
            r_if_pc1   <= w_if_pc1;
            r_if_valid <= w_if_valid;
        end
    end

    assign o_pc_out      = r_pc;
    assign o_imem_addr   = r_pc;
    assign o_imem_req    = w_req;
    assign o_if_id_instr = r_if_instr;
    assign o_if_id_pc1   = r_if_pc1;
    assign o_if_id_valid = r_if_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed stimulus against a fetch-stream scoreboard
// and a variable-latency instruction memory model.
module tb_fetch_stage;
    import fetch_pkg::*;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] br_target = '0;
    logic [W-1:0] pc_out;
    logic [W-1:0] pc_plus1;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_data = '0;
    logic         imem_valid = 1'b0;
    logic [W-1:0] if_id_instr;
    logic [W-1:0] if_id_pc1;
    logic         if_id_valid;

    int checks = 0;
    int failures = 0;
    int presented = 0;
    int lat_mode = 1;
    bit inject = 1'b0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0] nxt_pc = '0;

    fetch_stage dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_br_target  (br_target),
        .o_pc_out     (pc_out),
        .i_pc_plus1   (pc_plus1),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_data  (imem_data),
        .i_imem_valid (imem_valid),
        .o_if_id_instr(if_id_instr),
        .o_if_id_pc1  (if_id_pc1),
        .o_if_id_valid(if_id_valid)
    );

    always #5 clock = ~clock;
    assign pc_plus1 = pc_out + 16'd1;

    function automatic logic [W-1:0] mem(input logic [W-1:0] a);
        return (a == 16'h0004) ? 16'hB00B : 16'hA001 + a;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Memory: one response per request, latency counted from the first request cycle.
    initial begin : memory
        bit pend;
        int cnt;
        logic [W-1:0] paddr;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        forever begin
            @(posedge clock);
            #1;
            imem_valid = 1'b0;
            if (inject) begin
                imem_valid = 1'b1;
                imem_data = 16'hDEAD;
                inject = 1'b0;
            end
            if (reset) pend = 1'b0;
            else begin
                if (pend && imem_req) chk("imem_addr_stable", imem_addr, paddr);
                if (!pend && imem_req) begin
                    pend = 1'b1;
                    paddr = imem_addr;
                    cnt = (lat_mode == 0 ? int'($urandom_range(1, 3)) : lat_mode) - 1;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        imem_valid = 1'b1;
                        imem_data = mem(paddr);
                        pend = 1'b0;
                    end else cnt--;
                end
            end
        end
    end

    // Reference: decode must see consecutive {mem(pc), pc+1} starting at reset PC or branch target.
    initial begin : model
        forever begin
            @(posedge clock);
            if (reset) begin
                exp_q.delete();
                nxt_pc = RESET_PC;
            end else if (flush) begin
                exp_q.delete();
                nxt_pc = br_target;
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back({mem(nxt_pc), nxt_pc + 16'd1});
                nxt_pc = nxt_pc + 16'd1;
            end
        end
    end

    initial begin : monitor
        logic [2*W-1:0] e;
        forever begin
            @(negedge clock);
            if (!reset && if_id_valid && !stall) begin
                presented++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ifid_unexpected: got %h expected nothing", {if_id_instr, if_id_pc1});
                end else begin
                    e = exp_q.pop_front();
                    chk("ifid_stream", {if_id_instr, if_id_pc1}, e);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int p0;
        reset = 1'b1;
        repeat (2) tick();
        chk("rst_pc", pc_out, RESET_PC);
        chk("rst_req", imem_req, 0);
        chk("rst_ifid", {if_id_instr, if_id_pc1, if_id_valid}, 0);
        reset = 1'b0;
        chk("boot_req", imem_req, 0);
        tick();
        chk("fetch0_req", imem_req, 1);
        chk("fetch0_addr", imem_addr, 16'h0000);
        tick();
        chk("fetch1_addr", imem_addr, 16'h0001);
        chk("ifid0", {if_id_instr, if_id_pc1, if_id_valid}, {16'hA001, 16'h0001, 1'b1});
        tick();
        chk("ifid1", {if_id_instr, if_id_pc1, if_id_valid}, {16'hA002, 16'h0002, 1'b1});

        n = 0;
        while (!(imem_valid && imem_addr == 16'h0004) && n < 20) begin tick(); n++; end
        chk("reach_pc4", imem_valid && imem_addr == 16'h0004, 1);
        stall = 1'b1;
        tick();
        chk("hold_req", imem_req, 0);
        chk("hold_ifid", {if_id_instr, if_id_pc1}, {16'hA004, 16'h0004});
        tick();
        stall = 1'b0;
        tick();
        chk("unstall_ifid", {if_id_instr, if_id_pc1, if_id_valid}, {16'hB00B, 16'h0005, 1'b1});
        chk("unstall_addr", imem_addr, 16'h0005);

        lat_mode = 3;
        n = 0;
        while (!(imem_req && !imem_valid) && n < 10) begin tick(); n++; end
        chk("outstanding", imem_req && !imem_valid, 1);
        flush = 1'b1;
        br_target = 16'h0040;
        tick();
        flush = 1'b0;
        chk("discard_req", imem_req, 0);
        chk("discard_pc", pc_out, 16'h0040);
        n = 0;
        while (!imem_req && n < 10) begin
            chk("discard_ifid_valid", if_id_valid, 0);
            tick();
            n++;
        end
        chk("redirect_addr", {imem_req, imem_addr}, {1'b1, 16'h0040});

        lat_mode = 1;
        n = 0;
        while (!imem_valid && n < 10) begin tick(); n++; end
        flush = 1'b1;
        stall = 1'b1;
        br_target = 16'h0080;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        chk("fsv_ifid_valid", if_id_valid, 0);
        chk("fsv_pc", pc_out, 16'h0080);
        chk("fsv_fetch", {imem_req, imem_addr}, {1'b1, 16'h0080});

        flush = 1'b1;
        br_target = 16'hFFFF;
        tick();
        flush = 1'b0;
        n = 0;
        while (!(imem_valid && imem_addr == 16'hFFFF) && n < 10) begin tick(); n++; end
        tick();
        chk("wrap_ifid", {if_id_instr, if_id_pc1}, {16'hA000, 16'h0000});
        chk("wrap_addr", imem_addr, 16'h0000);

        lat_mode = 0;
        repeat (1500) begin
            stall = ($urandom_range(0, 99) < 30);
            flush = ($urandom_range(0, 99) < 4);
            br_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom());
            tick();
        end
        stall = 1'b0;
        flush = 1'b0;
        repeat (10) tick();
        chk("progress", presented > 150, 1);

        lat_mode = 3;
        n = 0;
        while (!(imem_req && !imem_valid) && n < 10) begin tick(); n++; end
        #1 reset = 1'b1;
        #1;
        chk("async_rst_pc", pc_out, RESET_PC);
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_ifid", {if_id_instr, if_id_pc1, if_id_valid}, 0);
        @(posedge clock);
        inject = 1'b1;
        #2 reset = 1'b0;
        chk("boot_valid_seen", imem_valid, 1);
        chk("boot_req2", imem_req, 0);
        tick();
        chk("post_boot_fetch", {imem_req, imem_addr}, {1'b1, RESET_PC});
        chk("post_boot_ifid", if_id_valid, 0);
        p0 = presented;
        lat_mode = 1;
        repeat (30) tick();
        chk("post_reset_progress", presented > p0 + 5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
